ldst_sequencer: RTL
===================

# ldst_sequencer

Multi-cycle sequencer for D-type memory instructions (LDUR/STUR) at the EX/MEM boundary of the pipelined ARM64 core. It takes a D-type operation with its base register and sign-extended 9-bit offset, forms the effective address, runs a request/acknowledge transaction with data memory, and stalls the pipeline until the transaction completes. It then presents load data to writeback, or reports a fault on timeout or misalignment.

## Interface
Parameters:
- DATA_W, 64, width of address, base, offset and data buses
- TIMEOUT_CYCLES, 255, maximum REQ cycles without mem_ack before fault; must be ≥1

Ports:
- clk  in  1  core clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op_valid  in  1  D-type memory op present in EX
- op_is_load  in  1  1 = LDUR, 0 = STUR
- base  in  DATA_W  Rn value
- imm_ext  in  DATA_W  sign-extended D-type offset
- st_data  in  DATA_W  Rt value for stores
- rd_in  in  5  destination register for loads
- stall  out  1  hold EX and earlier stages
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  DATA_W  effective address
- mem_wdata  out  DATA_W  store data
- mem_ack  in  1  memory completion
- mem_rdata  in  DATA_W  load data, valid with mem_ack
- wb_valid  out  1  one-cycle pulse, load result valid
- wb_rd  out  5  load destination
- wb_data  out  DATA_W  load result
- fault  out  1  one-cycle pulse, op aborted

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - op_valid=1 → capture op_is_load, rd_in, st_data and addr = base + imm_ext (modulo 2^DATA_W, wrap ignored); go to REQ.
  - stall is combinationally 1 in the accept cycle.
- REQ:
  - mem_req=1. mem_we, mem_addr and mem_wdata are held from the registered capture.
  - mem_ack=1 → latch mem_rdata for loads; go to DONE.
  - Timeout counter increments every REQ cycle without ack. Reaching TIMEOUT_CYCLES → drop request, set fault_pending, go to DONE.
- DONE:
  - stall=0; the pipeline advances at the end of this cycle.
  - wb_valid=1 only for a completed load; stores produce no wb_valid.
  - fault=1 if fault_pending.
  - Unconditionally go to IDLE.
  - op_valid in DONE is the op just completed and is ignored.
- stall = (state==IDLE && op_valid) || state==REQ.
- mem_ack outside REQ is ignored.
- Reset, asynchronous and possibly mid-transaction: state=IDLE; counter=0; mem_req, mem_we, stall, wb_valid, fault = 0; mem_addr, mem_wdata, wb_data = 0; wb_rd = 0. The memory side must tolerate an abandoned request.

## Timing
- Cycle 0: op accepted, stall=1.
- Cycle 1: mem_req=1 from a register, no combinational path from the op inputs.
- Ack in the first REQ cycle gives the minimum latency: DONE in cycle 2, wb_valid and stall=0 in cycle 2, next op accepted in cycle 3.
- Each extra ack-wait cycle adds one cycle of latency.
- Timeout: mem_req is high for exactly TIMEOUT_CYCLES cycles, then DONE with fault.
- mem_ack and timeout reached in the same cycle: ack wins, no fault.
- wb_data and wb_rd hold their last values outside wb_valid.

## Configuration
- Macro LDST_ALIGN_CHECK_EN.
- Defined:
  - In the IDLE accept cycle, addr[2:0] != 0 → IDLE goes directly to DONE with fault=1.
  - mem_req is never asserted and stall is 1 only in the accept cycle.
- Undefined: no alignment check; any address is issued.

## Structure
- Package ldst_pkg holds:
  - the state enum (IDLE, REQ, DONE)
  - DATA_W default
  - the op-kind typedef (LOAD/STORE)
- Sub-module ldst_addr_gen is a purely combinational base + imm_ext adder with the misalignment flag output. The misalignment flag is used only when LDST_ALIGN_CHECK_EN is defined.
- Timeout counter and FSM are inline.

## Test plan
- Load, immediate ack: base=0x1000, imm_ext=0xFFFF_FFFF_FFFF_FFF8 (−8), rd_in=3, mem_ack in first REQ cycle, mem_rdata=0xDEAD → mem_addr=0xFF8; wb_valid in cycle 2 with wb_rd=3, wb_data=0xDEAD; stall high for cycles 0–1 only.
- Store, 3-cycle ack wait: base=0x20, imm_ext=0x10, st_data=0x55 → mem_we=1, mem_addr=0x30, mem_wdata=0x55 held for 4 REQ cycles; no wb_valid; no fault.
- Timeout: TIMEOUT_CYCLES=4, mem_ack held 0 → mem_req high exactly 4 cycles; fault pulse; wb_valid=0; next op accepted normally.
- Ack on timeout cycle: TIMEOUT_CYCLES=4, mem_ack on the 4th REQ cycle → completes normally, fault=0.
- Reset mid-REQ: assert reset during the 2nd REQ cycle → mem_req, stall and the other outputs drop to 0 immediately without waiting for a clock edge; after release, op_valid low → stays IDLE.
- LDST_ALIGN_CHECK_EN defined: base=0x1003, imm_ext=0 → no mem_req; fault in cycle 1; stall only in cycle 0.

Source files
------------

// File: rtl/ldst_pkg.sv
// rtl/ldst_pkg.sv - shared types and defaults for the D-type load/store sequencer
package ldst_pkg;

   localparam int LDST_DATA_W = 64;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic {
      OP_STORE = 1'b0,
      OP_LOAD  = 1'b1
   } op_kind_t;

endpackage

// File: rtl/ldst_addr_gen.sv
// rtl/ldst_addr_gen.sv - effective address adder (base + offset) with doubleword misalignment flag
module ldst_addr_gen
   import ldst_pkg::*;
#(
   parameter int DATA_W = LDST_DATA_W
) (
   input  logic [DATA_W-1:0] i_base,
   input  logic [DATA_W-1:0] i_imm,
   output logic [DATA_W-1:0] o_addr,
   output logic              o_misalign
);

   // Carry out of the top bit is dropped: addresses wrap modulo 2^DATA_W.
   assign o_addr     = i_base + i_imm;
   assign o_misalign = (o_addr[2:0] != 3'b000);

endmodule

// File: rtl/ldst_sequencer.sv
// rtl/ldst_sequencer.sv - LDUR/STUR request/ack sequencer with pipeline stall, timeout and fault.
// Optional alignment fault on accept when LDST_ALIGN_CHECK_EN is defined.
module ldst_sequencer
   import ldst_pkg::*;
#(
   parameter int DATA_W         = LDST_DATA_W,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              op_valid,
   input  logic              op_is_load,
   input  logic [DATA_W-1:0] base,
   input  logic [DATA_W-1:0] imm_ext,
   input  logic [DATA_W-1:0] st_data,
   input  logic [4:0]        rd_in,
   output logic              stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              wb_valid,
   output logic [4:0]        wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              fault
);

   localparam int             CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t              r_state;
   op_kind_t            r_kind;
   logic [CNT_W-1:0]    r_cnt;
   logic [4:0]          r_rd;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [DATA_W-1:0]   r_mem_addr;
   logic [DATA_W-1:0]   r_mem_wdata;
   logic                r_wb_valid;
   logic [4:0]          r_wb_rd;
   logic [DATA_W-1:0]   r_wb_data;
   logic                r_fault;

   logic [DATA_W-1:0]   w_addr;
   logic                w_misalign;
   logic                w_align_fault;

   ldst_addr_gen #(
      .DATA_W (DATA_W)
   ) u_addr_gen (
      .i_base     (base),
      .i_imm      (imm_ext),
      .o_addr     (w_addr),
      .o_misalign (w_misalign)
   );

`ifdef LDST_ALIGN_CHECK_EN
   assign w_align_fault = w_misalign;
`else
   logic w_unused_misalign;
   assign w_unused_misalign = w_misalign;
   assign w_align_fault     = 1'b0;
`endif

   // Stall is the only combinational output: the accept cycle must freeze EX immediately.
   assign stall = ((r_state == IDLE) && op_valid) || (r_state == REQ);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_kind      <= OP_STORE;
         r_cnt       <= '0;
         r_rd        <= '0;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_wb_valid  <= 1'b0;
         r_wb_rd     <= '0;
         r_wb_data   <= '0;
         r_fault     <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         r_fault    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (op_valid) begin
                  r_kind <= op_is_load ? OP_LOAD : OP_STORE;
                  r_rd   <= rd_in;
                  r_cnt  <= '0;
                  if (w_align_fault) begin
                     r_fault <= 1'b1;
                     r_state <= DONE;
                  end else begin
                     r_mem_addr  <= w_addr;
                     r_mem_wdata <= st_data;
                     r_mem_we    <= ~op_is_load;
                     r_mem_req   <= 1'b1;
                     r_state     <= REQ;
                  end
               end
            end
            REQ: begin
               // Ack is tested first so an ack on the last allowed cycle still completes.
               if (mem_ack) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  if (r_kind == OP_LOAD) begin
                     r_wb_valid <= 1'b1;
                     r_wb_rd    <= r_rd;
                     r_wb_data  <= mem_rdata;
                  end
                  r_state <= DONE;
               end else if (r_cnt == CNT_LAST) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  r_fault   <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign wb_valid  = r_wb_valid;
   assign wb_rd     = r_wb_rd;
   assign wb_data   = r_wb_data;
   assign fault     = r_fault;

endmodule
